// File: rtl/rv32i_pkg.sv
// Core-wide RV32I datapath widths and the common data bus packet shared by
// the processing units, the write-back arbiter and the reservation stations.
package rv32i_pkg;

  localparam int REG_FILE_BW          = 32;
  localparam int PHYS_REG_FILE_IDX_BW = 6;
  localparam int ROB_IDX_BW           = 5;

  typedef struct packed {
    logic [PHYS_REG_FILE_IDX_BW-1:0] tag;
    logic [REG_FILE_BW-1:0]          data;
    logic [ROB_IDX_BW-1:0]           rob_idx;
  } cdb_pkt_t;

endpackage

// File: rtl/rv32i_rr_arbiter.sv
// Generic N-way round-robin arbiter: one-hot grant in the request cycle,
// pointer advances to one past the winner on every grant.
module rv32i_rr_arbiter #(
  parameter int N      = 4,
  parameter int PTR_BW = (N > 1) ? $clog2(N) : 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              i_en,
  input  logic [N-1:0]      i_req,
  output logic [N-1:0]      o_gnt,
  output logic              o_vld,
  output logic [PTR_BW-1:0] o_idx
);

  logic [PTR_BW-1:0] r_ptr;
  logic [N-1:0]      w_gnt;
  logic              w_vld;
  logic [PTR_BW-1:0] w_idx;
  logic [PTR_BW-1:0] w_ptr_nxt;

  // Search upward from the pointer, modulo N; first pending request wins.
  always_comb begin : search
    logic [PTR_BW:0] w_cand;
    w_gnt  = '0;
    w_vld  = 1'b0;
    w_idx  = '0;
    w_cand = '0;
    for (int k = 0; k < N; k++) begin
      w_cand = {1'b0, r_ptr} + (PTR_BW+1)'(k);
      if (w_cand >= (PTR_BW+1)'(N)) begin
        w_cand = w_cand - (PTR_BW+1)'(N);
      end else begin
        w_cand = w_cand;
      end
      if (i_en && !rst && !w_vld && i_req[w_cand[PTR_BW-1:0]]) begin
        w_gnt[w_cand[PTR_BW-1:0]] = 1'b1;
        w_vld                     = 1'b1;
        w_idx                     = w_cand[PTR_BW-1:0];
      end else begin
        w_vld = w_vld;
      end
    end
  end

  // Next pointer: one past the winner, wrapping after the last requester.
  always_comb begin
    if (w_idx == PTR_BW'(N-1)) begin
      w_ptr_nxt = '0;
    end else begin
      w_ptr_nxt = w_idx + PTR_BW'(1);
    end
  end

  // Pointer register; holds when nothing is granted.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_ptr <= '0;
    end else if (w_vld) begin
      r_ptr <= w_ptr_nxt;
    end else begin
      r_ptr <= r_ptr;
    end
  end

  assign o_gnt = w_gnt;
  assign o_vld = w_vld;
  assign o_idx = w_idx;

endmodule

// File: rtl/rv32i_cdb_arbiter.sv
// Common data bus write-back arbiter: picks one finished result per cycle
// round-robin and broadcasts it, registered, on the following cycle.
module rv32i_cdb_arbiter
  import rv32i_pkg::*;
#(
  parameter int NUM_PU = 4,
  parameter int PTR_BW = $clog2(NUM_PU)
) (
  input  logic                                        clk,
  input  logic                                        rst,
  input  logic                                        i_flush,
  input  logic [NUM_PU-1:0]                           i_req,
  input  logic [NUM_PU-1:0][PHYS_REG_FILE_IDX_BW-1:0] i_tag,
  input  logic [NUM_PU-1:0][REG_FILE_BW-1:0]          i_data,
  input  logic [NUM_PU-1:0][ROB_IDX_BW-1:0]           i_rob_idx,
  output logic [NUM_PU-1:0]                           o_gnt,
  output logic                                        o_wb_vld,
  output logic [PHYS_REG_FILE_IDX_BW-1:0]             o_wb_tag,
  output logic [REG_FILE_BW-1:0]                      o_wb_data,
  output logic [ROB_IDX_BW-1:0]                       o_wb_rob_idx
);

  logic [NUM_PU-1:0] w_gnt;
  logic              w_vld;
  logic [PTR_BW-1:0] w_idx;
  cdb_pkt_t          w_pkt;
  logic              r_wb_vld;
  cdb_pkt_t          r_wb_pkt;

  rv32i_rr_arbiter #(
    .N      (NUM_PU),
    .PTR_BW (PTR_BW)
  ) u_arb (
    .clk   (clk),
    .rst   (rst),
    .i_en  (~i_flush),
    .i_req (i_req),
    .o_gnt (w_gnt),
    .o_vld (w_vld),
    .o_idx (w_idx)
  );

  // Payload mux selected by the winning requester.
  always_comb begin
    w_pkt.tag     = i_tag[w_idx];
    w_pkt.data    = i_data[w_idx];
    w_pkt.rob_idx = i_rob_idx[w_idx];
  end

  // Broadcast register; payload holds while no result is granted.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_wb_vld <= 1'b0;
      r_wb_pkt <= '0;
    end else if (w_vld) begin
      r_wb_vld <= 1'b1;
      r_wb_pkt <= w_pkt;
    end else begin
      r_wb_vld <= 1'b0;
      r_wb_pkt <= r_wb_pkt;
    end
  end

  assign o_gnt        = w_gnt;
  assign o_wb_vld     = r_wb_vld;
  assign o_wb_tag     = r_wb_pkt.tag;
  assign o_wb_data    = r_wb_pkt.data;
  assign o_wb_rob_idx = r_wb_pkt.rob_idx;

endmodule

// File: tb/tb_rv32i_cdb_arbiter.sv
// Scoreboard bench for rv32i_cdb_arbiter with four processing units.
module tb_rv32i_cdb_arbiter;
  import rv32i_pkg::*;

  localparam int NPU = 4;

  logic clk = 1'b0;
  logic rst;
  logic i_flush;
  logic [NPU-1:0]                           i_req;
  logic [NPU-1:0][PHYS_REG_FILE_IDX_BW-1:0] i_tag;
  logic [NPU-1:0][REG_FILE_BW-1:0]          i_data;
  logic [NPU-1:0][ROB_IDX_BW-1:0]           i_rob_idx;
  logic [NPU-1:0]                           o_gnt;
  logic                                     o_wb_vld;
  logic [PHYS_REG_FILE_IDX_BW-1:0]          o_wb_tag;
  logic [REG_FILE_BW-1:0]                   o_wb_data;
  logic [ROB_IDX_BW-1:0]                    o_wb_rob_idx;

  cdb_pkt_t exp_q[$];
  int       total = 0;
  int       bad   = 0;
  logic [1:0] m_ptr;

  rv32i_cdb_arbiter #(.NUM_PU(NPU)) dut (
    .clk          (clk),
    .rst          (rst),
    .i_flush      (i_flush),
    .i_req        (i_req),
    .i_tag        (i_tag),
    .i_data       (i_data),
    .i_rob_idx    (i_rob_idx),
    .o_gnt        (o_gnt),
    .o_wb_vld     (o_wb_vld),
    .o_wb_tag     (o_wb_tag),
    .o_wb_data    (o_wb_data),
    .o_wb_rob_idx (o_wb_rob_idx)
  );

  always #5 clk = ~clk;

  function automatic logic [NPU-1:0] model_gnt(input logic [NPU-1:0] req, input logic [1:0] ptr);
    model_gnt = '0;
    for (int k = 0; k < NPU; k++) begin
      int c;
      c = (int'(ptr) + k) % NPU;
      if (req[c]) begin
        model_gnt[c] = 1'b1;
        return model_gnt;
      end
    end
  endfunction

  function automatic cdb_pkt_t pkt_of(input int idx);
    pkt_of.tag     = i_tag[idx];
    pkt_of.data    = i_data[idx];
    pkt_of.rob_idx = i_rob_idx[idx];
  endfunction

  // Model bookkeeping for an expected grant: queue its payload, advance ptr.
  task automatic note_grant(input logic [NPU-1:0] g);
    for (int i = 0; i < NPU; i++) begin
      if (g[i]) begin
        exp_q.push_back(pkt_of(i));
        m_ptr = (i == NPU-1) ? 2'd0 : 2'(i + 1);
      end
    end
  endtask

  task automatic set_payloads();
    for (int i = 0; i < NPU; i++) begin
      i_tag[i]     = 6'(8'h10 + i);
      i_data[i]    = 32'hA5A5_0000 | 32'(i);
      i_rob_idx[i] = 5'(i + 8);
    end
  endtask

  task automatic test_reset();
    cdb_pkt_t e;
    rst = 1'b1; i_flush = 1'b0; i_req = 4'b1111;
    for (int c = 0; c < 2; c++) begin
      #1;
      total++;
      if (o_gnt !== 4'b0000) begin bad++; $display("FAIL reset_gnt[%0d]: got %b want 0000", c, o_gnt); end
      @(posedge clk); #1;
      total++;
      if (o_wb_vld !== 1'b0 || o_wb_tag !== 6'd0 || o_wb_data !== 32'd0 || o_wb_rob_idx !== 5'd0) begin
        bad++; $display("FAIL reset_out[%0d]: vld=%b tag=%h data=%h rob=%h want all 0", c, o_wb_vld, o_wb_tag, o_wb_data, o_wb_rob_idx);
      end
    end
    rst = 1'b0; m_ptr = 2'd0;
    #1;
    total++;
    if (o_gnt !== 4'b0001) begin bad++; $display("FAIL reset_first_gnt: got %b want 0001", o_gnt); end
    note_grant(4'b0001);
    @(posedge clk); #1;
    e = exp_q.pop_front();
    total++;
    if (o_wb_vld !== 1'b1 || {o_wb_tag, o_wb_data, o_wb_rob_idx} !== e) begin
      bad++; $display("FAIL reset_first_wb: vld=%b pkt=%h want 1 %h", o_wb_vld, {o_wb_tag, o_wb_data, o_wb_rob_idx}, e);
    end
    i_req = 4'b0000;
    @(posedge clk); #1;
    total++;
    if (o_wb_vld !== 1'b0) begin bad++; $display("FAIL reset_idle_vld: got %b want 0", o_wb_vld); end
  endtask

  task automatic test_single();
    cdb_pkt_t e;
    i_tag[2] = 6'h05; i_data[2] = 32'hdaddad00; i_rob_idx[2] = 5'd3;
    i_req = 4'b0100; i_flush = 1'b0;
    #1;
    total++;
    if (o_gnt !== 4'b0100) begin bad++; $display("FAIL single_gnt: got %b want 0100", o_gnt); end
    e = '{tag: 6'h05, data: 32'hdaddad00, rob_idx: 5'd3};
    @(posedge clk); #1;
    i_req = 4'b0000;
    total++;
    if (o_wb_vld !== 1'b1 || {o_wb_tag, o_wb_data, o_wb_rob_idx} !== e) begin
      bad++; $display("FAIL single_wb: vld=%b pkt=%h want 1 %h", o_wb_vld, {o_wb_tag, o_wb_data, o_wb_rob_idx}, e);
    end
    total++;
    if (dut.u_arb.r_ptr !== 2'd3) begin bad++; $display("FAIL single_ptr: got %0d want 3", dut.u_arb.r_ptr); end
    m_ptr = 2'd3;
    set_payloads();
  endtask

  task automatic test_wrap();
    logic [3:0] t_req [3] = '{4'b1001, 4'b0001, 4'b0000};
    logic [3:0] t_gnt [3] = '{4'b1000, 4'b0001, 4'b0000};
    cdb_pkt_t e;
    for (int c = 0; c < 3; c++) begin
      i_req = t_req[c]; i_flush = 1'b0; #1;
      total++;
      if (o_gnt !== t_gnt[c]) begin bad++; $display("FAIL wrap_gnt[%0d]: got %b want %b", c, o_gnt, t_gnt[c]); end
      note_grant(t_gnt[c]);
      @(posedge clk); #1;
      e = (t_gnt[c] != 4'b0000) ? exp_q.pop_front() : '0;
      total++;
      if (o_wb_vld !== (t_gnt[c] != 4'b0000) || (o_wb_vld && {o_wb_tag, o_wb_data, o_wb_rob_idx} !== e)) begin
        bad++; $display("FAIL wrap_wb[%0d]: vld=%b pkt=%h want pkt %h", c, o_wb_vld, {o_wb_tag, o_wb_data, o_wb_rob_idx}, e);
      end
      total++;
      if (dut.u_arb.r_ptr !== m_ptr) begin bad++; $display("FAIL wrap_ptr[%0d]: got %0d want %0d", c, dut.u_arb.r_ptr, m_ptr); end
    end
  endtask

  task automatic test_flush();
    logic [3:0] t_req [5] = '{4'b0010, 4'b0010, 4'b0001, 4'b0001, 4'b0000};
    logic       t_fl  [5] = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b0};
    logic [3:0] t_gnt [5] = '{4'b0000, 4'b0010, 4'b0000, 4'b0001, 4'b0000};
    cdb_pkt_t e;
    for (int c = 0; c < 5; c++) begin
      i_req = t_req[c]; i_flush = t_fl[c]; #1;
      total++;
      if (o_gnt !== t_gnt[c]) begin bad++; $display("FAIL flush_gnt[%0d]: got %b want %b", c, o_gnt, t_gnt[c]); end
      note_grant(t_gnt[c]);
      @(posedge clk); #1;
      e = (t_gnt[c] != 4'b0000) ? exp_q.pop_front() : '0;
      total++;
      if (o_wb_vld !== (t_gnt[c] != 4'b0000) || (o_wb_vld && {o_wb_tag, o_wb_data, o_wb_rob_idx} !== e)) begin
        bad++; $display("FAIL flush_wb[%0d]: vld=%b pkt=%h want pkt %h", c, o_wb_vld, {o_wb_tag, o_wb_data, o_wb_rob_idx}, e);
      end
      total++;
      if (dut.u_arb.r_ptr !== m_ptr) begin bad++; $display("FAIL flush_ptr[%0d]: got %0d want %0d", c, dut.u_arb.r_ptr, m_ptr); end
    end
    i_flush = 1'b0;
  endtask

  task automatic test_back_to_back();
    logic [3:0] t_gnt [6] = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001, 4'b0000};
    cdb_pkt_t e;
    rst = 1'b1; i_req = 4'b1111; #1;
    total++;
    if (o_gnt !== 4'b0000) begin bad++; $display("FAIL midrst_gnt: got %b want 0000", o_gnt); end
    @(posedge clk); #1;
    m_ptr = 2'd0;
    total++;
    if (o_wb_vld !== 1'b0 || dut.u_arb.r_ptr !== 2'd0) begin
      bad++; $display("FAIL midrst_out: vld=%b ptr=%0d want 0 0", o_wb_vld, dut.u_arb.r_ptr);
    end
    rst = 1'b0;
    for (int c = 0; c < 6; c++) begin
      i_req = (c < 5) ? 4'b1111 : 4'b0000; #1;
      total++;
      if (o_gnt !== t_gnt[c]) begin bad++; $display("FAIL b2b_gnt[%0d]: got %b want %b", c, o_gnt, t_gnt[c]); end
      note_grant(t_gnt[c]);
      @(posedge clk); #1;
      e = (t_gnt[c] != 4'b0000) ? exp_q.pop_front() : '0;
      total++;
      if (o_wb_vld !== (t_gnt[c] != 4'b0000) || (o_wb_vld && {o_wb_tag, o_wb_data, o_wb_rob_idx} !== e)) begin
        bad++; $display("FAIL b2b_wb[%0d]: vld=%b pkt=%h want pkt %h", c, o_wb_vld, {o_wb_tag, o_wb_data, o_wb_rob_idx}, e);
      end
    end
  endtask

  task automatic test_hold();
    logic [3:0] t_req [6] = '{4'b0100, 4'b1011, 4'b1011, 4'b1011, 4'b1001, 4'b0000};
    logic [3:0] t_gnt [6] = '{4'b0100, 4'b1000, 4'b0001, 4'b0010, 4'b1000, 4'b0000};
    cdb_pkt_t e;
    int n_pu1_wb = 0;
    int first_pu1 = -1;
    i_tag[1] = 6'h02; i_data[1] = 32'hfadecafe; i_rob_idx[1] = 5'd7;
    for (int c = 0; c < 6; c++) begin
      i_req = t_req[c]; #1;
      total++;
      if (o_gnt !== t_gnt[c]) begin bad++; $display("FAIL hold_gnt[%0d]: got %b want %b", c, o_gnt, t_gnt[c]); end
      if (o_gnt[1] && first_pu1 < 0) first_pu1 = c;
      note_grant(t_gnt[c]);
      @(posedge clk); #1;
      if (o_wb_vld && o_wb_tag == 6'h02 && o_wb_data == 32'hfadecafe) n_pu1_wb++;
      e = (t_gnt[c] != 4'b0000) ? exp_q.pop_front() : '0;
      total++;
      if (o_wb_vld !== (t_gnt[c] != 4'b0000) || (o_wb_vld && {o_wb_tag, o_wb_data, o_wb_rob_idx} !== e)) begin
        bad++; $display("FAIL hold_wb[%0d]: vld=%b pkt=%h want pkt %h", c, o_wb_vld, {o_wb_tag, o_wb_data, o_wb_rob_idx}, e);
      end
    end
    total++;
    if (n_pu1_wb != 1) begin bad++; $display("FAIL hold_once: pu1 broadcasts=%0d want 1", n_pu1_wb); end
    total++;
    if (first_pu1 < 1 || first_pu1 > 4) begin bad++; $display("FAIL hold_latency: pu1 granted at cycle %0d want 1..4", first_pu1); end
    set_payloads();
  endtask

  task automatic test_random();
    logic [3:0] pend = 4'b0000;
    logic [3:0] exp_g;
    cdb_pkt_t e;
    for (int c = 0; c < 300; c++) begin
      for (int i = 0; i < NPU; i++) begin
        if (!pend[i] && $urandom_range(0, 1) == 1) begin
          pend[i]      = 1'b1;
          i_tag[i]     = 6'($urandom);
          i_data[i]    = $urandom;
          i_rob_idx[i] = 5'($urandom);
        end
      end
      i_req   = pend;
      i_flush = ($urandom_range(0, 9) == 0);
      rst     = ($urandom_range(0, 49) == 0);
      #1;
      exp_g = (rst || i_flush) ? 4'b0000 : model_gnt(pend, m_ptr);
      total++;
      if (o_gnt !== exp_g) begin bad++; $display("FAIL rand_gnt[%0d]: got %b want %b", c, o_gnt, exp_g); end
      note_grant(exp_g);
      pend = pend & ~exp_g;
      @(posedge clk); #1;
      if (rst) m_ptr = 2'd0;
      e = (exp_g != 4'b0000) ? exp_q.pop_front() : '0;
      total++;
      if (o_wb_vld !== (exp_g != 4'b0000) || (o_wb_vld && {o_wb_tag, o_wb_data, o_wb_rob_idx} !== e)) begin
        bad++; $display("FAIL rand_wb[%0d]: vld=%b pkt=%h want pkt %h", c, o_wb_vld, {o_wb_tag, o_wb_data, o_wb_rob_idx}, e);
      end
      total++;
      if (dut.u_arb.r_ptr !== m_ptr) begin bad++; $display("FAIL rand_ptr[%0d]: got %0d want %0d", c, dut.u_arb.r_ptr, m_ptr); end
    end
    rst = 1'b0; i_flush = 1'b0; i_req = 4'b0000;
  endtask

  initial begin
    rst = 1'b1; i_flush = 1'b0; i_req = 4'b0000; m_ptr = 2'd0;
    set_payloads();
    test_reset();
    test_single();
    test_wrap();
    test_flush();
    test_back_to_back();
    test_hold();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
